// File: rtl/mem_burst_rd_responder.sv
// Memory-side endpoint for aligned line-burst reads: waits FIRST_LAT cycles, then streams
// BURST_LEN words lowest-first with optional idle gaps, from an array preloaded via init_*.
module mem_burst_rd_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned BURST_LEN  = 8,
  parameter int unsigned FIRST_LAT  = 4,
  parameter int unsigned BEAT_GAP   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_rd_req_valid,
  input  logic [31:0]           mem_rd_req_addr,
  output logic                  mem_rd_req_ready,
  output logic                  mem_rd_rsp_valid,
  output logic [31:0]           mem_rd_rsp_data,
  output logic                  mem_rd_rsp_last,
  input  logic                  mem_rd_rsp_ready,
  input  logic                  init_we,
  input  logic [ADDR_WIDTH-1:0] init_addr,
  input  logic [31:0]           init_data,
  output logic                  busy
);

  localparam int unsigned BeatW = $clog2(BURST_LEN);
  localparam int unsigned OffW  = $clog2(4 * BURST_LEN);
  localparam int unsigned BaseW = ADDR_WIDTH - BeatW;

  localparam logic [BeatW-1:0] LastBeat  = BeatW'(BURST_LEN - 1);
  localparam logic [7:0]       FirstLat8 = 8'(FIRST_LAT);
  localparam logic [7:0]       BeatGap8  = 8'(BEAT_GAP);

  typedef enum logic [1:0] {StIdle, StLat, StBeat, StGap} state_e;

  state_e           state_q;
  logic [BaseW-1:0] base_q;
  logic [BeatW-1:0] beat_q;
  logic [7:0]       cnt_q;
  logic             req_ready_q;
  logic             rsp_valid_q;
  logic             rsp_last_q;
  logic             busy_q;

  logic [31:0] mem [2**ADDR_WIDTH];

  // Byte offset within the line and bits above the array are intentionally dropped.
  logic unused_addr;
  assign unused_addr = ^{mem_rd_req_addr[31:ADDR_WIDTH+2], mem_rd_req_addr[OffW-1:0]};

  always_ff @(posedge clk) begin
    if (init_we && state_q == StIdle) begin
      mem[init_addr] <= init_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      beat_q      <= '0;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (mem_rd_req_valid) begin
            base_q      <= mem_rd_req_addr[ADDR_WIDTH+1:OffW];
            beat_q      <= '0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            rsp_last_q  <= 1'b0;
            if (FIRST_LAT == 0) begin
              state_q     <= StBeat;
              rsp_valid_q <= 1'b1;
            end else begin
              state_q <= StLat;
              cnt_q   <= FirstLat8;
            end
          end
        end
        StLat: begin
          if (cnt_q <= 8'd1) begin
            state_q     <= StBeat;
            rsp_valid_q <= 1'b1;
            rsp_last_q  <= (beat_q == LastBeat);
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        StBeat: begin
          if (mem_rd_rsp_ready) begin
            if (beat_q == LastBeat) begin
              state_q     <= StIdle;
              req_ready_q <= 1'b1;
              rsp_valid_q <= 1'b0;
              rsp_last_q  <= 1'b0;
              busy_q      <= 1'b0;
            end else begin
              beat_q <= beat_q + BeatW'(1);
              if (BEAT_GAP == 0) begin
                rsp_last_q <= (beat_q + BeatW'(1) == LastBeat);
              end else begin
                state_q     <= StGap;
                cnt_q       <= BeatGap8;
                rsp_valid_q <= 1'b0;
                rsp_last_q  <= 1'b0;
              end
            end
          end
        end
        StGap: begin
          if (cnt_q <= 8'd1) begin
            state_q     <= StBeat;
            rsp_valid_q <= 1'b1;
            rsp_last_q  <= (beat_q == LastBeat);
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem_rd_req_ready = req_ready_q;
  assign mem_rd_rsp_valid = rsp_valid_q;
  assign mem_rd_rsp_last  = rsp_last_q;
  assign busy             = busy_q;
  assign mem_rd_rsp_data  = mem[{base_q, beat_q}];

endmodule
